// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the memory.
// Single outstanding request: req/gnt for the address phase, rvalid/rdata for read return.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: data-memory stage behind the instruction controller.
// Latches one access in IDLE, drives the req/gnt/rvalid bus, extends load data
// and returns a one-cycle ready/valid pulse in DONE.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN to add the
// 'misaligned' output and skip the bus for misaligned half/word accesses.
//
// state  | meaning
// IDLE   | waiting for memory_en; latches the access
// REQ    | mem_req high until mem_gnt (or timeout)
// WAIT_R | store accepted / load waiting for mem_rvalid (or timeout)
// DONE   | one-cycle completion pulse, then back to IDLE
module load_store_unit #(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        memory_en,
    input  logic [1:0]  store_size,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        mem_write_ready,
    output logic        mem_read_data_valid,
    output logic [31:0] load_data,
    output logic        bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t          state, state_nxt;
    logic            we_r;
    logic [31:0]     addr_r;
    logic [1:0]      lane_r;
    logic [2:0]      funct3_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wstrb_r;
    logic [TO_W-1:0] to_cnt;
    logic            to_err;
    logic            flushed;
    logic            kill;
    logic            to_hit;
    logic            timeout;
    logic [3:0]      st_wstrb;
    logic [31:0]     st_wdata;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [31:0]     ext_data;
    logic            done_ok;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            is_half;
    logic            is_word;
    logic            mis_now;
    logic            mis_r;
`endif

    // Once the controller drops memory_en the access is flushed: no pulse, no load_data update.
    assign kill    = flushed | ~memory_en;
    assign to_hit  = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
    assign timeout = to_hit && (((state == REQ) && !bus.mem_gnt) ||
                                ((state == WAIT_R) && !bus.mem_rvalid));

`ifdef LSU_MISALIGN_TRAP_EN
    // Classify the incoming access width; undefined load funct3 counts as a word.
    always_comb begin
        is_half = (store_size == 2'b01) || ((store_size == 2'b11) && (funct3[1:0] == 2'b01));
        is_word = (store_size == 2'b10) ||
                  ((store_size == 2'b11) && (funct3 != 3'b000) && (funct3 != 3'b100) &&
                   (funct3[1:0] != 2'b01));
        mis_now = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    end
`endif

    // Store lane placement: replicate data across lanes and pick byte enables.
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = wdata_in;
        case (store_size)
            2'b00: begin
                st_wstrb = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << {addr[1], 1'b0};
                st_wdata = {2{wdata_in[15:0]}};
            end
            2'b10:   st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        byte_val = bus.mem_rdata[{lane_r, 3'b000} +: 8];
        half_val = bus.mem_rdata[{lane_r[1], 4'b0000} +: 16];
        case (funct3_r)
            3'b000:  ext_data = {{24{byte_val[7]}}, byte_val};
            3'b001:  ext_data = {{16{half_val[15]}}, half_val};
            3'b100:  ext_data = {24'h000000, byte_val};
            3'b101:  ext_data = {16'h0000, half_val};
            default: ext_data = bus.mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a bus response wins over a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (memory_en) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_nxt = mis_now ? DONE : REQ;
`else
                    state_nxt = REQ;
`endif
                end
            end
            REQ: begin
                if (bus.mem_gnt) state_nxt = we_r ? DONE : WAIT_R;
                else if (to_hit) state_nxt = DONE;
            end
            WAIT_R: begin
                if (bus.mem_rvalid || to_hit) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access latch, timeout counter, flush tracking and load result register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            we_r      <= 1'b0;
            addr_r    <= '0;
            lane_r    <= '0;
            funct3_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            to_cnt    <= '0;
            to_err    <= 1'b0;
            flushed   <= 1'b0;
            load_data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (memory_en) begin
                        we_r     <= (store_size != 2'b11);
                        addr_r   <= {addr[31:2], 2'b00};
                        lane_r   <= addr[1:0];
                        funct3_r <= funct3;
                        wdata_r  <= st_wdata;
                        wstrb_r  <= st_wstrb;
                        to_cnt   <= '0;
                        to_err   <= 1'b0;
                        flushed  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        mis_r    <= mis_now;
`endif
                    end
                end
                REQ, WAIT_R: begin
                    if (!memory_en) flushed <= 1'b1;
                    if (state_nxt != state) to_cnt <= '0;
                    else                    to_cnt <= to_cnt + 1'b1;
                    if (timeout) begin
                        to_err <= 1'b1;
                        if (!we_r && !kill) load_data <= '0;
                    end
                    if ((state == WAIT_R) && bus.mem_rvalid && !kill) load_data <= ext_data;
                end
                default: ;
            endcase
        end
    end

    // Bus drive and completion pulses decoded from state.
    always_comb begin
        bus.mem_req         = (state == REQ);
        bus.mem_we          = we_r;
        bus.mem_addr        = addr_r;
        bus.mem_wdata       = wdata_r;
        bus.mem_wstrb       = wstrb_r;
        done_ok             = (state == DONE) && !kill;
        mem_write_ready     = done_ok && we_r;
        mem_read_data_valid = done_ok && !we_r;
        bus_err             = done_ok && to_err;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned          = done_ok && mis_r;
`endif
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one default-timeout instance (a) and one
// with TIMEOUT_CYC=4 (b). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        en_a, en_b;
    logic [1:0]  store_size;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        wr_a, rv_a, be_a, wr_b, rv_b, be_b;
    logic [31:0] ld_a, ld_b;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          found;

    load_store_unit_if bus_a ();
    load_store_unit_if bus_b ();

    load_store_unit dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .memory_en(en_a), .store_size(store_size),
        .funct3(funct3), .addr(addr), .wdata_in(wdata_in),
        .mem_write_ready(wr_a), .mem_read_data_valid(rv_a), .load_data(ld_a),
        .bus_err(be_a), .bus(bus_a)
    );

    load_store_unit #(.TIMEOUT_CYC(4), .TO_W(8)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .memory_en(en_b), .store_size(store_size),
        .funct3(funct3), .addr(addr), .wdata_in(wdata_in),
        .mem_write_ready(wr_b), .mem_read_data_valid(rv_b), .load_data(ld_b),
        .bus_err(be_b), .bus(bus_b)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Store on dut_a with gnt in the first REQ cycle; pulse expected in the 3rd cycle.
    task automatic run_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        store_size = sz; addr = a; wdata_in = wd; en_a = 1'b1; bus_a.mem_gnt = 1'b1;
        tick();
        chk1 ({tag, " req"},   bus_a.mem_req, 1'b1);
        chk1 ({tag, " we"},    bus_a.mem_we, 1'b1);
        chk32({tag, " addr"},  bus_a.mem_addr, exp_addr);
        chk32({tag, " wstrb"}, 32'(bus_a.mem_wstrb), 32'(exp_strb));
        chk32({tag, " wdata"}, bus_a.mem_wdata, exp_wd);
        chk1 ({tag, " early"}, wr_a, 1'b0);
        tick();
        bus_a.mem_gnt = 1'b0;
        chk1 ({tag, " ready"}, wr_a, 1'b1);
        chk1 ({tag, " req_off"}, bus_a.mem_req, 1'b0);
        en_a = 1'b0;
        tick();
        chk1 ({tag, " ready_1cyc"}, wr_a, 1'b0);
    endtask

    // Load on dut_a: gnt in first REQ cycle, rvalid 'gap' cycles after gnt.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input int gap, input logic [31:0] exp);
        store_size = 2'b11; funct3 = f3; addr = a; en_a = 1'b1; bus_a.mem_gnt = 1'b1;
        tick();
        chk1 ({tag, " req"},   bus_a.mem_req, 1'b1);
        chk1 ({tag, " we"},    bus_a.mem_we, 1'b0);
        chk32({tag, " wstrb"}, 32'(bus_a.mem_wstrb), 32'h0);
        chk32({tag, " addr"},  bus_a.mem_addr, {a[31:2], 2'b00});
        tick();
        bus_a.mem_gnt = 1'b0;
        for (int i = 1; i < gap; i++) begin
            chk1({tag, " wait_req"}, bus_a.mem_req, 1'b0);
            chk1({tag, " wait_rv"},  rv_a, 1'b0);
            tick();
        end
        chk1({tag, " req_low"}, bus_a.mem_req, 1'b0);
        bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = rd;
        tick();
        bus_a.mem_rvalid = 1'b0; bus_a.mem_rdata = 32'h0;
        chk1 ({tag, " valid"}, rv_a, 1'b1);
        chk1 ({tag, " err"},   be_a, 1'b0);
        chk32({tag, " data"},  ld_a, exp);
        en_a = 1'b0;
        tick();
        chk1 ({tag, " valid_1cyc"}, rv_a, 1'b0);
        chk32({tag, " data_hold"}, ld_a, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; en_a = 1'b0; en_b = 1'b0;
        store_size = 2'b00; funct3 = 3'b000; addr = 32'h0; wdata_in = 32'h0;
        bus_a.mem_gnt = 1'b0; bus_a.mem_rvalid = 1'b0; bus_a.mem_rdata = 32'h0;
        bus_b.mem_gnt = 1'b0; bus_b.mem_rvalid = 1'b0; bus_b.mem_rdata = 32'h0;
        tick();
        tick();
        chk1 ("rst req",   bus_a.mem_req, 1'b0);
        chk1 ("rst we",    bus_a.mem_we, 1'b0);
        chk32("rst addr",  bus_a.mem_addr, 32'h0);
        chk32("rst wstrb", 32'(bus_a.mem_wstrb), 32'h0);
        chk32("rst load",  ld_a, 32'h0);
        chk1 ("rst valid", rv_a, 1'b0);
        RESET_N = 1'b1;
        tick();

        run_store("SB", 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
        run_store("SH", 2'b01, 32'h0000_1002, 32'h1234_BEEF, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF);
        run_store("SW", 2'b10, 32'h0000_1004, 32'h0BAD_F00D, 32'h0000_1004, 4'b1111, 32'h0BAD_F00D);

        run_load("LB",  3'b000, 32'h0000_2001, 32'h1234_F0CC, 2, 32'hFFFF_FFF0);
        run_load("LBU", 3'b100, 32'h0000_2001, 32'h1234_F0CC, 2, 32'h0000_00F0);
        run_load("LH",  3'b001, 32'h0000_2002, 32'h8001_ABCD, 1, 32'hFFFF_8001);
        run_load("LHU", 3'b101, 32'h0000_2002, 32'h8001_ABCD, 1, 32'h0000_8001);
        run_load("LH0", 3'b001, 32'h0000_2000, 32'h0000_ABCD, 1, 32'hFFFF_ABCD);
        run_load("LW",  3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        run_load("LX",  3'b111, 32'h0000_2000, 32'h1357_9BDF, 1, 32'h1357_9BDF);

        // Gnt withheld 10 cycles, memory_en toggled low in cycle 3: request held, no pulse.
        store_size = 2'b00; addr = 32'h0000_4000; wdata_in = 32'h11; en_a = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) en_a = 1'b0;
            if (i == 4) en_a = 1'b1;
            chk1("flush req_held", bus_a.mem_req, 1'b1);
            chk1("flush no_ready", wr_a, 1'b0);
            tick();
        end
        bus_a.mem_gnt = 1'b1;
        tick();
        bus_a.mem_gnt = 1'b0;
        chk1("flush done_no_ready", wr_a, 1'b0);
        en_a = 1'b0;
        tick();
        chk1("flush req_off", bus_a.mem_req, 1'b0);
        chk1("flush idle_no_ready", wr_a, 1'b0);

        // dut_b: a good load first so the timeout clearing load_data is visible.
        store_size = 2'b11; funct3 = 3'b010; addr = 32'h0000_5000; en_b = 1'b1;
        bus_b.mem_gnt = 1'b1;
        tick();
        tick();
        bus_b.mem_gnt = 1'b0; bus_b.mem_rvalid = 1'b1; bus_b.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus_b.mem_rvalid = 1'b0; bus_b.mem_rdata = 32'h0;
        chk1 ("b load valid", rv_b, 1'b1);
        chk32("b load data", ld_b, 32'hCAFE_F00D);
        en_b = 1'b0;
        tick();

        // Timeout in WAIT_R: bus_err and valid together, load_data cleared.
        en_b = 1'b1; bus_b.mem_gnt = 1'b1;
        tick();
        tick();
        bus_b.mem_gnt = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (rv_b) found = 1'b1;
        end
        chk1 ("to pulse_seen", found, 1'b1);
        chk1 ("to bus_err", be_b, 1'b1);
        chk32("to load_zero", ld_b, 32'h0);
        en_b = 1'b0;
        tick();
        chk1 ("to err_1cyc", be_b, 1'b0);
        bus_b.mem_rvalid = 1'b1; bus_b.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus_b.mem_rvalid = 1'b0;
        chk1 ("late rv_ignored", rv_b, 1'b0);
        chk32("late data_kept", ld_b, 32'h0);
        tick();
        chk1 ("late rv_ignored2", rv_b, 1'b0);

        // Reset while dut_a waits for rvalid.
        store_size = 2'b11; funct3 = 3'b010; addr = 32'h0000_6004; en_a = 1'b1;
        bus_a.mem_gnt = 1'b1;
        tick();
        tick();
        bus_a.mem_gnt = 1'b0;
        tick();
        RESET_N = 1'b0;
        tick();
        chk1 ("midrst req",   bus_a.mem_req, 1'b0);
        chk1 ("midrst we",    bus_a.mem_we, 1'b0);
        chk32("midrst addr",  bus_a.mem_addr, 32'h0);
        chk32("midrst wdata", bus_a.mem_wdata, 32'h0);
        chk32("midrst wstrb", 32'(bus_a.mem_wstrb), 32'h0);
        chk32("midrst load",  ld_a, 32'h0);
        chk1 ("midrst valid", rv_a, 1'b0);
        chk1 ("midrst ready", wr_a, 1'b0);
        chk1 ("midrst err",   be_a, 1'b0);
        en_a = 1'b0; RESET_N = 1'b1;
        tick();
        run_store("SW_post_rst", 2'b10, 32'h0000_3000, 32'h89AB_CDEF, 32'h0000_3000, 4'b1111, 32'h89AB_CDEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory stage directly downstream of the instruction controller.
- Consumes the controller's memory_en / store_size qualifiers, the ALU-computed address and the rs2 store data.
- Drives a single-outstanding req/gnt/rvalid data-memory bus.
- Returns mem_write_ready / mem_read_data_valid, which the controller turns into its stall, plus the sign/zero-extended load data for the register write-back mux (wdSelect 01).

Parameters:
- TIMEOUT_CYC, 255: max cycles waiting for gnt or rvalid before aborting with bus_err; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- memory_en  in  1  current instruction accesses memory (from controller).
- store_size  in  2  00 byte, 01 half, 10 word store; 11 = load.
- funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr  in  32  byte address (ALU result).
- wdata_in  in  32  store data (rs2).
- mem_write_ready  out  1  store complete (1-cycle pulse).
- mem_read_data_valid  out  1  load data valid (1-cycle pulse).
- load_data  out  32  extended load result; held until next load completes.
- bus_err  out  1  1-cycle pulse on timeout; coincides with the ready/valid pulse.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, bits[1:0] = 00.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0000 on reads.
- mem_gnt  in  1  bus accepted request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.

Behaviour:
- Reset: RESET_N sampled low at edge → state IDLE; all outputs 0 (load_data = 0, mem_* = 0), timeout counter = 0.
- Reset mid-transaction abandons the access; mem_req drops at the reset edge.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - memory_en=1 → latch addr, size, funct3, wdata and mem_we (store_size != 11).
  - Next state REQ with mem_req registered high.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata held stable.
  - mem_req stays high until mem_gnt; no withdrawal even if memory_en drops.
  - gnt & we → DONE.
  - gnt & !we → WAIT_R.
  - A same-cycle mem_rvalid with gnt is ignored; rvalid is only accepted in WAIT_R.
- WAIT_R: mem_req = 0. On mem_rvalid, extend the selected lane into load_data (registered) → DONE.
- DONE:
  - Pulse mem_write_ready (store) or mem_read_data_valid (load) for exactly one cycle.
  - → IDLE unconditionally; this guarantees the retiring instruction is not reissued.
  - A back-to-back memory op starts in the following IDLE cycle.
- Latency:
  - Store with gnt on the first REQ cycle: ready pulse 3 cycles after memory_en is first seen (IDLE→REQ→DONE).
  - Load with rvalid 1 cycle after gnt: valid pulse 4 cycles after memory_en is first seen.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: wstrb = 0011 << {addr[1],0}; wdata = {2{half}}.
  - SW: wstrb = 1111.
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined funct3 → treated as LW.
- memory_en dropping after IDLE exits (flush): the access completes on the bus but the DONE pulse is suppressed and load_data is not updated.
- Timeout:
  - Counter clears on entering REQ or WAIT_R and increments each cycle there.
  - Reaching TIMEOUT_CYC → DONE with bus_err = 1; a load returns load_data = 0.
  - A bus response after timeout is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1 or word with addr[1:0]!=00 skips the bus: IDLE→DONE directly.
  - New output misaligned (1 bit) pulses with the ready/valid pulse.
  - No memory write occurs; a load leaves load_data unchanged.
- Undefined: no misaligned port; offending low address bits are ignored and the access behaves as naturally aligned.

Test Plan:
- SB, addr=0x1003, wdata_in=0x000000A5, gnt on first REQ cycle → mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, mem_write_ready pulse 3 cycles after memory_en.
- LB, addr=0x2001, mem_rdata=0x1234F0CC, rvalid 2 cycles after gnt → load_data=0xFFFFFFF0. Same access with LBU → 0x000000F0.
- LH, addr=0x2002, rdata=0x8001ABCD → load_data=0xFFFF8001; one valid pulse only; mem_req low from WAIT_R onward.
- Gnt withheld 10 cycles with memory_en toggled low at cycle 3 → mem_req stays high until gnt; no ready pulse.
- TIMEOUT_CYC=4, no rvalid → bus_err and mem_read_data_valid pulse together, load_data=0. A late rvalid afterwards causes no change.
- RESET_N low during WAIT_R → next cycle all outputs 0, state IDLE. A following SW to 0x3000 completes normally with wstrb=1111.
